// File: rtl/rv32_pkg.sv
// Shared RV32 control definitions: opcodes, select encodings, the ID/EX
// control bundle and the issue-control state type.
package rv32_pkg;

   localparam logic [6:0] OC_R      = 7'b0110011;
   localparam logic [6:0] OC_I      = 7'b0010011;
   localparam logic [6:0] OC_LOAD   = 7'b0000011;
   localparam logic [6:0] OC_STORE  = 7'b0100011;
   localparam logic [6:0] OC_BRANCH = 7'b1100011;
   localparam logic [6:0] OC_LUI    = 7'b0110111;
   localparam logic [6:0] OC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OC_JAL    = 7'b1101111;
   localparam logic [6:0] OC_JALR   = 7'b1100111;
   localparam logic [6:0] OC_P      = 7'b1110111;

   // funct7 bit that marks a packed-SIMD op as multiply-class (multi-cycle)
   localparam int PMUL_BIT = 6;

   typedef enum logic [2:0] {Imm_I, Imm_S, Imm_B, Imm_U, Imm_J} imm_sel_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_BSEL
   } alu_sel_t;

   typedef enum logic [1:0] {WB_MEM, WB_ALU, WB_PC4} wb_sel_t;

   typedef enum logic [1:0] {SIMD_8 = 2'b00, SIMD_16 = 2'b01, SIMD_32 = 2'b10} simd_w_t;

   typedef enum logic {RUN, PBUSY} ctrl_state_t;

   typedef struct packed {
      imm_sel_t   ImmSel;
      alu_sel_t   ALUSel;
      wb_sel_t    WBSel;
      logic       BrUn;
      logic       ASel;
      logic       BSel;
      logic       MemRW;
      logic       MemUnsigned;
      logic       RegWEn;
      logic [1:0] MemSize;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] funct3;
      logic       is_branch;
      logic       is_jump;
      logic       illegal;
      simd_w_t    simd_w;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_RESET = '{
      ImmSel: Imm_I, ALUSel: ALU_ADD, WBSel: WB_ALU,
      BrUn: 1'b0, ASel: 1'b0, BSel: 1'b0, MemRW: 1'b0, MemUnsigned: 1'b0,
      RegWEn: 1'b0, MemSize: 2'b00, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
      funct3: 3'd0, is_branch: 1'b0, is_jump: 1'b0, illegal: 1'b0,
      simd_w: SIMD_8
   };

   // A bubble keeps the datapath fields but must not write state or redirect.
   function automatic ctrl_bundle_t make_bubble(input ctrl_bundle_t b);
      ctrl_bundle_t r;
      r           = b;
      r.RegWEn    = 1'b0;
      r.MemRW     = 1'b0;
      r.is_branch = 1'b0;
      r.is_jump   = 1'b0;
      r.illegal   = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/rv32_ctrl_decode.sv
// Combinational RV32I + packed-SIMD control decode: instruction to control
// bundle, source-register usage flags and multiply-class indication.
module rv32_ctrl_decode
   import rv32_pkg::*;
#(
   parameter bit PEXT_EN = 1'b1
) (
   input  logic [31:0]  instr,
   output ctrl_bundle_t ctrl,
   output logic         rs1_used,
   output logic         rs2_used,
   output logic         pmul
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       illegal;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Table-driven decode; reserved encodings fall through to the illegal path.
   always_comb begin
      ctrl          = CTRL_RESET;
      ctrl.rd       = instr[11:7];
      ctrl.rs1      = instr[19:15];
      ctrl.rs2      = instr[24:20];
      ctrl.funct3   = funct3;
      rs1_used      = 1'b0;
      rs2_used      = 1'b0;
      pmul          = 1'b0;
      illegal       = 1'b0;

      case (opcode)
         OC_R, OC_I: begin
            ctrl.BSel   = (opcode == OC_I);
            ctrl.RegWEn = 1'b1;
            rs1_used    = 1'b1;
            rs2_used    = (opcode == OC_R);
            case (funct3)
               3'b000: ctrl.ALUSel = (opcode == OC_R && funct7[5]) ? ALU_SUB : ALU_ADD;
               3'b001: ctrl.ALUSel = ALU_SLL;
               3'b010: ctrl.ALUSel = ALU_SLT;
               3'b011: ctrl.ALUSel = ALU_SLTU;
               3'b100: ctrl.ALUSel = ALU_XOR;
               3'b101: ctrl.ALUSel = funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110: ctrl.ALUSel = ALU_OR;
               default: ctrl.ALUSel = ALU_AND;
            endcase
            // funct7 is an encoding field for R-type and for immediate shifts
            if (opcode == OC_R || funct3 == 3'b001 || funct3 == 3'b101) begin
               if (funct7 == 7'b0100000)
                  illegal = !(funct3 == 3'b101 || (opcode == OC_R && funct3 == 3'b000));
               else
                  illegal = (funct7 != 7'b0000000);
            end
         end
         OC_LOAD: begin
            ctrl.BSel        = 1'b1;
            ctrl.WBSel       = WB_MEM;
            ctrl.RegWEn      = 1'b1;
            ctrl.MemSize     = funct3[1:0];
            ctrl.MemUnsigned = funct3[2];
            rs1_used         = 1'b1;
            illegal          = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OC_STORE: begin
            ctrl.ImmSel  = Imm_S;
            ctrl.BSel    = 1'b1;
            ctrl.MemRW   = 1'b1;
            ctrl.MemSize = funct3[1:0];
            rs1_used     = 1'b1;
            rs2_used     = 1'b1;
            illegal      = funct3[2] || (funct3[1:0] == 2'b11);
         end
         OC_BRANCH: begin
            ctrl.ImmSel    = Imm_B;
            ctrl.ASel      = 1'b1;
            ctrl.BSel      = 1'b1;
            ctrl.BrUn      = funct3[1];
            ctrl.is_branch = 1'b1;
            rs1_used       = 1'b1;
            rs2_used       = 1'b1;
            illegal        = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OC_LUI: begin
            ctrl.ImmSel = Imm_U;
            ctrl.BSel   = 1'b1;
            ctrl.ALUSel = ALU_BSEL;
            ctrl.RegWEn = 1'b1;
         end
         OC_AUIPC: begin
            ctrl.ImmSel = Imm_U;
            ctrl.ASel   = 1'b1;
            ctrl.BSel   = 1'b1;
            ctrl.RegWEn = 1'b1;
         end
         OC_JAL: begin
            ctrl.ImmSel  = Imm_J;
            ctrl.ASel    = 1'b1;
            ctrl.BSel    = 1'b1;
            ctrl.WBSel   = WB_PC4;
            ctrl.RegWEn  = 1'b1;
            ctrl.is_jump = 1'b1;
         end
         OC_JALR: begin
            ctrl.BSel    = 1'b1;
            ctrl.WBSel   = WB_PC4;
            ctrl.RegWEn  = 1'b1;
            ctrl.is_jump = 1'b1;
            rs1_used     = 1'b1;
            illegal      = (funct3 != 3'b000);
         end
         OC_P: begin
            if (PEXT_EN) begin
               ctrl.RegWEn = 1'b1;
               ctrl.simd_w = simd_w_t'(funct7[5:4]);
               rs1_used    = 1'b1;
               rs2_used    = 1'b1;
               // lane width 2'b11 has no meaning
               illegal     = (funct7[5:4] == 2'b11);
               pmul        = funct7[PMUL_BIT] && !illegal;
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase

      if (illegal) begin
         ctrl.illegal   = 1'b1;
         ctrl.RegWEn    = 1'b0;
         ctrl.MemRW     = 1'b0;
         ctrl.is_branch = 1'b0;
         ctrl.is_jump   = 1'b0;
         ctrl.simd_w    = SIMD_8;
         rs1_used       = 1'b0;
         rs2_used       = 1'b0;
      end
   end

endmodule

// File: rtl/rv32_ctrl_pipe.sv
// ID/EX control stage: decodes the ID instruction and registers its control
// bundle, with valid/ready handshake, load-use bubbles, flush and an issue
// hold for multi-cycle packed-SIMD multiplies.
//
//   state | meaning
//   RUN   | normal issue, one instruction per cycle when EX is ready
//   PBUSY | multiply-class OP-P occupying EX; issue bubbles until cnt expires
module rv32_ctrl_pipe
   import rv32_pkg::*;
#(
   parameter bit PEXT_EN     = 1'b1,
   parameter int PMUL_CYCLES = 3,
   parameter bit HAZARD_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [31:0] id_instr,
   input  logic        flush,
   input  logic        ex_ready,
   output logic        ex_valid,
   output imm_sel_t    ex_ImmSel,
   output alu_sel_t    ex_ALUSel,
   output wb_sel_t     ex_WBSel,
   output logic        ex_BrUn,
   output logic        ex_ASel,
   output logic        ex_BSel,
   output logic        ex_MemRW,
   output logic        ex_MemUnsigned,
   output logic        ex_RegWEn,
   output logic [1:0]  ex_MemSize,
   output logic [4:0]  ex_rd,
   output logic [4:0]  ex_rs1,
   output logic [4:0]  ex_rs2,
   output logic [2:0]  ex_funct3,
   output logic        ex_is_branch,
   output logic        ex_is_jump,
   output logic        ex_illegal,
   output logic [1:0]  ex_simd_w
);

   localparam int CNT_W = (PMUL_CYCLES > 2) ? $clog2(PMUL_CYCLES) : 1;

   ctrl_bundle_t      id_ctrl;
   ctrl_bundle_t      ex_ctrl;
   ctrl_state_t       state;
   logic [CNT_W-1:0]  cnt;
   logic              rs1_used;
   logic              rs2_used;
   logic              id_pmul;
   logic              ex_is_load;
   logic              load_use;
   logic              stall;
   logic              fire;

   rv32_ctrl_decode #(.PEXT_EN(PEXT_EN)) u_decode (
      .instr    (id_instr),
      .ctrl     (id_ctrl),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used),
      .pmul     (id_pmul)
   );

   // Hazard detection and ready generation; flush always drains ID.
   always_comb begin
      ex_is_load = ex_valid && ex_ctrl.RegWEn && (ex_ctrl.WBSel == WB_MEM);
      load_use   = 1'b0;
      if (HAZARD_EN && state == RUN && id_valid && ex_is_load && ex_ctrl.rd != 5'd0)
         load_use = (rs1_used && id_ctrl.rs1 == ex_ctrl.rd) ||
                    (rs2_used && id_ctrl.rs2 == ex_ctrl.rd);
      stall    = ex_valid && !ex_ready;
      id_ready = flush || (!stall && state == RUN && !load_use);
      fire     = id_valid && id_ready;
   end

   // ID/EX register and issue FSM, in priority rst > flush > stall > PBUSY > issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= CTRL_RESET;
         state    <= RUN;
         cnt      <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= make_bubble(ex_ctrl);
         state    <= RUN;
         cnt      <= '0;
      end else if (stall) begin
         ex_valid <= ex_valid;
      end else if (state == PBUSY) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= make_bubble(ex_ctrl);
         if (ex_ready) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1))
               state <= RUN;
         end
      end else if (fire) begin
         ex_valid <= 1'b1;
         ex_ctrl  <= id_ctrl;
         if (id_pmul && (PMUL_CYCLES > 1)) begin
            state <= PBUSY;
            cnt   <= CNT_W'(PMUL_CYCLES - 1);
         end
      end else begin
         ex_valid <= 1'b0;
         ex_ctrl  <= make_bubble(ex_ctrl);
      end
   end

   assign ex_ImmSel      = ex_ctrl.ImmSel;
   assign ex_ALUSel      = ex_ctrl.ALUSel;
   assign ex_WBSel       = ex_ctrl.WBSel;
   assign ex_BrUn        = ex_ctrl.BrUn;
   assign ex_ASel        = ex_ctrl.ASel;
   assign ex_BSel        = ex_ctrl.BSel;
   assign ex_MemRW       = ex_ctrl.MemRW;
   assign ex_MemUnsigned = ex_ctrl.MemUnsigned;
   assign ex_RegWEn      = ex_ctrl.RegWEn;
   assign ex_MemSize     = ex_ctrl.MemSize;
   assign ex_rd          = ex_ctrl.rd;
   assign ex_rs1         = ex_ctrl.rs1;
   assign ex_rs2         = ex_ctrl.rs2;
   assign ex_funct3      = ex_ctrl.funct3;
   assign ex_is_branch   = ex_ctrl.is_branch;
   assign ex_is_jump     = ex_ctrl.is_jump;
   assign ex_illegal     = ex_ctrl.illegal;
   assign ex_simd_w      = ex_ctrl.simd_w;

endmodule

// File: tb/tb_rv32_ctrl_pipe.sv
// Directed bench for rv32_ctrl_pipe with default parameters.
module tb_rv32_ctrl_pipe;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic        flush;
   logic        ex_ready;
   logic        ex_valid;
   imm_sel_t    ex_ImmSel;
   alu_sel_t    ex_ALUSel;
   wb_sel_t     ex_WBSel;
   logic        ex_BrUn, ex_ASel, ex_BSel, ex_MemRW, ex_MemUnsigned, ex_RegWEn;
   logic [1:0]  ex_MemSize;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;
   logic [2:0]  ex_funct3;
   logic        ex_is_branch, ex_is_jump, ex_illegal;
   logic [1:0]  ex_simd_w;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] I_LW_X5   = 32'h0000A283;
   localparam logic [31:0] I_ADD_X6  = 32'h00228333;
   localparam logic [31:0] I_LW_X0   = 32'h0000A003;
   localparam logic [31:0] I_ADD_X0S = 32'h00200333;
   localparam logic [31:0] I_PMUL16  = 32'hA03103F7;
   localparam logic [31:0] I_ADDI_X8 = 32'h00100413;
   localparam logic [31:0] I_ADDI_X9 = 32'h00100493;
   localparam logic [31:0] I_BAD_7F  = 32'h00000FFF;
   localparam logic [31:0] I_SW      = 32'h0020A223;

   rv32_ctrl_pipe dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
      .id_instr(id_instr), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
      .ex_ImmSel(ex_ImmSel), .ex_ALUSel(ex_ALUSel), .ex_WBSel(ex_WBSel),
      .ex_BrUn(ex_BrUn), .ex_ASel(ex_ASel), .ex_BSel(ex_BSel), .ex_MemRW(ex_MemRW),
      .ex_MemUnsigned(ex_MemUnsigned), .ex_RegWEn(ex_RegWEn), .ex_MemSize(ex_MemSize),
      .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3),
      .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_illegal(ex_illegal),
      .ex_simd_w(ex_simd_w)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_instr = 32'd0; flush = 1'b0; ex_ready = 1'b1;
      tick(); tick();

      // reset state
      rst = 1'b0; #1;
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_regwen", 32'(ex_RegWEn), 32'd0);
      chk("rst_memrw", 32'(ex_MemRW), 32'd0);
      chk("rst_id_ready", 32'(id_ready), 32'd1);
      chk("rst_immsel", 32'(ex_ImmSel), 32'(Imm_I));
      chk("rst_alusel", 32'(ex_ALUSel), 32'(ALU_ADD));
      chk("rst_wbsel", 32'(ex_WBSel), 32'(WB_ALU));
      tick();

      // load-use: lw x5 then add x6,x5,x2 -> one bubble
      id_valid = 1'b1; id_instr = I_LW_X5; #1;
      chk("lu_ready0", 32'(id_ready), 32'd1);
      tick();
      id_instr = I_ADD_X6; #1;
      chk("lu_valid1", 32'(ex_valid), 32'd1);
      chk("lu_lw_rd", 32'(ex_rd), 32'd5);
      chk("lu_lw_wb", 32'(ex_WBSel), 32'(WB_MEM));
      chk("lu_lw_size", 32'(ex_MemSize), 32'd2);
      chk("lu_ready1", 32'(id_ready), 32'd0);
      tick();
      chk("lu_valid2", 32'(ex_valid), 32'd0);
      chk("lu_bubble_we", 32'(ex_RegWEn), 32'd0);
      chk("lu_ready2", 32'(id_ready), 32'd1);
      tick();
      chk("lu_valid3", 32'(ex_valid), 32'd1);
      chk("lu_add_rd", 32'(ex_rd), 32'd6);
      chk("lu_add_we", 32'(ex_RegWEn), 32'd1);
      id_valid = 1'b0; tick();
      chk("idle_bubble", 32'(ex_valid), 32'd0);

      // x0 destination never causes a hazard
      id_valid = 1'b1; id_instr = I_LW_X0; tick();
      id_instr = I_ADD_X0S; #1;
      chk("x0_valid1", 32'(ex_valid), 32'd1);
      chk("x0_ready", 32'(id_ready), 32'd1);
      tick();
      chk("x0_valid2", 32'(ex_valid), 32'd1);
      chk("x0_rd", 32'(ex_rd), 32'd6);
      id_valid = 1'b0; tick();

      // store decode
      id_valid = 1'b1; id_instr = I_SW; tick();
      chk("sw_memrw", 32'(ex_MemRW), 32'd1);
      chk("sw_regwen", 32'(ex_RegWEn), 32'd0);
      chk("sw_immsel", 32'(ex_ImmSel), 32'(Imm_S));
      id_valid = 1'b0; tick();

      // P-ext multiply, 16-bit lanes, 3-cycle occupancy
      id_valid = 1'b1; id_instr = I_PMUL16; #1;
      chk("p_ready0", 32'(id_ready), 32'd1);
      tick();
      id_instr = I_ADDI_X8; #1;
      chk("p_valid1", 32'(ex_valid), 32'd1);
      chk("p_simd_w", 32'(ex_simd_w), 32'd1);
      chk("p_rd", 32'(ex_rd), 32'd7);
      chk("p_ready1", 32'(id_ready), 32'd0);
      tick();
      chk("p_valid2", 32'(ex_valid), 32'd0);
      chk("p_ready2", 32'(id_ready), 32'd0);
      tick();
      chk("p_valid3", 32'(ex_valid), 32'd0);
      chk("p_ready3", 32'(id_ready), 32'd1);
      tick();
      chk("p_valid4", 32'(ex_valid), 32'd1);
      chk("p_next_rd", 32'(ex_rd), 32'd8);
      id_valid = 1'b0; tick();

      // flush in the first PBUSY cycle
      id_valid = 1'b1; id_instr = I_PMUL16; tick();
      flush = 1'b1; id_instr = I_ADDI_X9; #1;
      chk("fl_ready_in", 32'(id_ready), 32'd1);
      tick();
      flush = 1'b0; #1;
      chk("fl_valid", 32'(ex_valid), 32'd0);
      chk("fl_ready", 32'(id_ready), 32'd1);
      tick();
      chk("fl_next_valid", 32'(ex_valid), 32'd1);
      chk("fl_next_rd", 32'(ex_rd), 32'd9);
      id_valid = 1'b0; tick();

      // backpressure with an illegal opcode held in EX
      id_valid = 1'b1; id_instr = I_BAD_7F; tick();
      id_instr = I_ADDI_X8; ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_valid", 32'(ex_valid), 32'd1);
         chk("bp_illegal", 32'(ex_illegal), 32'd1);
         chk("bp_regwen", 32'(ex_RegWEn), 32'd0);
         chk("bp_memrw", 32'(ex_MemRW), 32'd0);
         chk("bp_rd", 32'(ex_rd), 32'd31);
         chk("bp_ready", 32'(id_ready), 32'd0);
         tick();
      end
      ex_ready = 1'b1; #1;
      chk("bp_release_ready", 32'(id_ready), 32'd1);
      tick();
      chk("bp_after_valid", 32'(ex_valid), 32'd1);
      chk("bp_after_rd", 32'(ex_rd), 32'd8);
      chk("bp_after_illegal", 32'(ex_illegal), 32'd0);
      id_valid = 1'b0; tick();

      // reset in the middle of a P-ext hold leaves no residue
      id_valid = 1'b1; id_instr = I_PMUL16; tick();
      id_valid = 1'b0; rst = 1'b1; tick();
      rst = 1'b0; #1;
      chk("mr_valid", 32'(ex_valid), 32'd0);
      chk("mr_ready", 32'(id_ready), 32'd1);
      chk("mr_simd_w", 32'(ex_simd_w), 32'd0);
      id_valid = 1'b1; id_instr = I_ADDI_X9; tick();
      chk("mr_issue", 32'(ex_valid), 32'd1);
      chk("mr_issue_rd", 32'(ex_rd), 32'd9);
      id_valid = 1'b0; tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
